// File: rtl/reg_file_write_bank.sv
// Write side of the 32 x 32-bit MIPS register file: write decoder, register bank and write status.
// Optional feature macro REG_SP_GP_INIT_EN: reset loads SP_RESET into $sp (r29) and GP_RESET into $gp (r28).
module reg_file_write_bank #(
  parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC,
  parameter logic [31:0] GP_RESET = 32'h1000_8000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [4:0]    wr_addr,
  input  logic [31:0]   wr_data,
  output logic [1023:0] regs_flat,
  output logic          wr_done,
  output logic [4:0]    wr_last_addr
);

`ifdef REG_SP_GP_INIT_EN
  localparam bit init_en = 1'b1;
`else
  localparam bit init_en = 1'b0;
`endif

  // Register 0 has no storage at all, so it can never read anything but zero.
  logic [31:0] regs [1:31];
  logic [31:0] wr_sel;
  logic        commit;

  function automatic logic [31:0] reset_value(input int n);
    if (init_en && n == 29) return SP_RESET;
    if (init_en && n == 28) return GP_RESET;
    return 32'h0;
  endfunction

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_sel = '0;
    if (wr_en) wr_sel[wr_addr] = 1'b1;
    wr_sel[0] = 1'b0;
  end

  assign commit = |wr_sel;

  // NOTE: the register array is architectural state that software expects in a known value, so it is reset like any flop rather than left uninitialised as a RAM would be.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 1; n < 32; n++) regs[n] <= reset_value(n);
    end else begin
      for (int n = 1; n < 32; n++) begin
        if (wr_sel[n]) regs[n] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_done      <= 1'b0;
      wr_last_addr <= 5'd0;
    end else begin
      wr_done <= commit;
      if (commit) wr_last_addr <= wr_addr;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int n = 1; n < 32; n++) regs_flat[32*n +: 32] = regs[n];
  end

endmodule
